// File: rtl/regfile_rw_pkg.sv
// Shared constants and types for the register file and the destination mux.
// Optional macro consumers: REGFILE_R0_ZERO_EN (register 0 hardwired to zero).
package regfile_rw_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int LINK_REG = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Destination mux select, shared with the write-address mux upstream.
    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RS = 2'd2,
        REGDST_R7 = 2'd3
    } regdst_e;

endpackage

// File: rtl/regfile_rw_array.sv
// Storage array: synchronous reset, one write port, two combinational read
// ports and a fixed tap on one register. Honours REGFILE_R0_ZERO_EN.
module regfile_array
    import regfile_rw_pkg::*;
#(
    parameter int TAP_IDX = LINK_REG
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_we,
    input  addr_t i_wa,
    input  data_t i_wd,
    input  addr_t i_ra1,
    input  addr_t i_ra2,
    output data_t o_rd1,
    output data_t o_rd2,
    output data_t o_tap
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_mem;
    logic                            w_we;

`ifdef REGFILE_R0_ZERO_EN
    assign w_we  = i_we && (i_wa != '0);
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
`else
    assign w_we  = i_we;
    assign o_rd1 = r_mem[i_ra1];
    assign o_rd2 = r_mem[i_ra2];
`endif

    assign o_tap = r_mem[TAP_IDX];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else if (w_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

endmodule

// File: rtl/regfile_rw.sv
// Register file with A/B operand latch, same-edge write forwarding into A/B
// and a link-register tap. Optional: REGFILE_R0_ZERO_EN.
module regfile_rw
    import regfile_rw_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  RegWrite,
    input  addr_t wa,
    input  data_t wd,
    input  addr_t ra1,
    input  addr_t ra2,
    output data_t rd1,
    output data_t rd2,
    input  logic  LoadAB,
    output data_t A,
    output data_t B,
    output data_t link
);

    data_t r_a;
    data_t r_b;
    data_t w_rd1;
    data_t w_rd2;
    logic  w_wr_ok;
    logic  w_fwd1;
    logic  w_fwd2;

    regfile_array #(
        .TAP_IDX (LINK_REG)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (RegWrite),
        .i_wa    (wa),
        .i_wd    (wd),
        .i_ra1   (ra1),
        .i_ra2   (ra2),
        .o_rd1   (w_rd1),
        .o_rd2   (w_rd2),
        .o_tap   (link)
    );

    // A dropped write to r0 must never be forwarded into A/B.
`ifdef REGFILE_R0_ZERO_EN
    assign w_wr_ok = RegWrite && (wa != '0);
`else
    assign w_wr_ok = RegWrite;
`endif

    assign w_fwd1 = w_wr_ok && (wa == ra1);
    assign w_fwd2 = w_wr_ok && (wa == ra2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (LoadAB) begin
            r_a <= w_fwd1 ? wd : w_rd1;
            r_b <= w_fwd2 ? wd : w_rd2;
        end
    end

    assign rd1 = w_rd1;
    assign rd2 = w_rd2;
    assign A   = r_a;
    assign B   = r_b;

endmodule

// File: tb/tb_regfile_rw.sv
// Self-checking bench for regfile_rw: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_rw;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        LoadAB;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] link;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] m_regs [16];
    logic [15:0] m_a;
    logic [15:0] m_b;

    regfile_rw dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RegWrite (RegWrite),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .LoadAB   (LoadAB),
        .A        (A),
        .B        (B),
        .link     (link)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [3:0] a);
        if (R0_ZERO && a == 4'd0) return 16'h0000;
        return m_regs[a];
    endfunction

    // One clock edge: the model applies reset / load-with-forwarding / write.
    task automatic cycle();
        bit ok;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
            m_a = 16'h0000;
            m_b = 16'h0000;
        end else begin
            ok = RegWrite && !(R0_ZERO && wa == 4'd0);
            if (LoadAB) begin
                m_a = (ok && wa == ra1) ? wd : model_rd(ra1);
                m_b = (ok && wa == ra2) ? wd : model_rd(ra2);
            end
            if (ok) m_regs[wa] = wd;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, rd1, model_rd(ra1));
        chk({tag, ".rd2"}, rd2, model_rd(ra2));
        chk({tag, ".A"}, A, m_a);
        chk({tag, ".B"}, B, m_b);
        chk({tag, ".link"}, link, model_rd(4'd7));
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        LoadAB   = 1'b0;
        wa       = 4'd0;
        wd       = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 16'hxxxx;
        m_a = 16'hxxxx;
        m_b = 16'hxxxx;
        rst_n = 1'b0;
        ra1 = 4'd0;
        ra2 = 4'd0;
        idle();

        // Reset for two cycles, then sweep read addresses.
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a);
            ra2 = 4'(15 - a);
            #1;
            check_all("reset");
            chk("reset.rd1_const", rd1, 16'h0000);
            chk("reset.A_const", A, 16'h0000);
        end

        // Basic write/read with one-cycle latency.
        RegWrite = 1'b1; wa = 4'd3; wd = 16'hBEEF; ra1 = 4'd3; ra2 = 4'd4;
        #1;
        chk("wr.no_writethrough", rd1, 16'h0000);
        cycle();
        idle();
        #1;
        chk("wr.rd1", rd1, 16'hBEEF);
        chk("wr.rd2", rd2, 16'h0000);
        check_all("wr");

        // Forwarding: write and load the same register on one edge.
        RegWrite = 1'b1; wa = 4'd5; wd = 16'h1111;
        cycle();
        RegWrite = 1'b1; wa = 4'd5; wd = 16'h2222; LoadAB = 1'b1; ra1 = 4'd5; ra2 = 4'd5;
        cycle();
        idle();
        #1;
        chk("fwd.A", A, 16'h2222);
        chk("fwd.B", B, 16'h2222);
        chk("fwd.rd1", rd1, 16'h2222);
        check_all("fwd");

        // Link register tap; A/B must hold without LoadAB.
        RegWrite = 1'b1; wa = 4'd7; wd = 16'h0040;
        cycle();
        idle();
        #1;
        chk("link.val", link, 16'h0040);
        chk("link.A_hold", A, 16'h2222);
        chk("link.B_hold", B, 16'h2222);

        // Reset mid-operation discards same-edge write and load.
        RegWrite = 1'b1; wa = 4'd2; wd = 16'h5555;
        cycle();
        rst_n = 1'b0; RegWrite = 1'b1; wa = 4'd2; wd = 16'hFFFF; LoadAB = 1'b1; ra1 = 4'd2; ra2 = 4'd2;
        cycle();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rstmid.reg2", rd1, 16'h0000);
        chk("rstmid.A", A, 16'h0000);
        chk("rstmid.B", B, 16'h0000);
        chk("rstmid.link", link, 16'h0000);

        // Register 0 behaviour depends on the build option.
        RegWrite = 1'b1; wa = 4'd0; wd = 16'h1234;
        cycle();
        idle();
        ra1 = 4'd0; ra2 = 4'd0; LoadAB = 1'b1;
        cycle();
        idle();
        #1;
        chk("r0.rd1", rd1, R0_ZERO ? 16'h0000 : 16'h1234);
        chk("r0.A", A, R0_ZERO ? 16'h0000 : 16'h1234);
        RegWrite = 1'b1; wa = 4'd0; wd = 16'h4321; LoadAB = 1'b1;
        cycle();
        idle();
        #1;
        chk("r0.fwdA", A, R0_ZERO ? 16'h0000 : 16'h4321);

        // Randomized traffic; addresses biased low to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            RegWrite = $urandom_range(0, 1) == 1;
            LoadAB   = $urandom_range(0, 2) == 0;
            wd       = 16'($urandom);
            ra1      = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            ra2      = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            if (!RegWrite && $urandom_range(0, 3) == 0)
                wa = 4'bxxxx;
            else
                wa = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            cycle();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
